stq_ram_mp: RTL and testbench
=============================

Name: stq_ram_mp

Overview:
- Parametrised multi-read, multi-write store-queue data RAM; successor to the single-write STQ array in the LSU.
- Adds N write ports with fixed priority, optional write-to-read bypass, partition gating and a hardware clear sequencer.
- Clear sequencer runs after reset and on partition re-activation; an explicit ready output reports when the array is usable.

Parameters:
RPORT, 2, number of asynchronous read ports
WPORT, 2, number of write ports
DEPTH, 16, entries; power of two, multiple of NUM_PARTS
INDEX, 4, log2(DEPTH)
WIDTH, 8, bits per entry
NUM_PARTS, 4, partitions; each covers DEPTH/NUM_PARTS contiguous entries
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
addr_i  in  RPORT*INDEX  read addresses; port r at [r*INDEX +: INDEX]
data_o  out  RPORT*WIDTH  read data; port r at [r*WIDTH +: WIDTH]
addrWr_i  in  WPORT*INDEX  write addresses
dataWr_i  in  WPORT*WIDTH  write data
wrEn_i  in  WPORT  per-port write enable
partActive_i  in  NUM_PARTS  1 = partition powered/usable
ramReady_o  out  1  1 = no clear in progress; writes accepted

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Partition index of an address: addr[INDEX-1 : INDEX-log2(NUM_PARTS)].
- FSM states: CLEAR, READY.
- Reset:
  - reset=1 at an edge: state<=CLEAR, clrIdx<=0, clrMask<=all ones, ramReady_o<=0.
  - Array contents are not reset directly; they are cleared by the sweep.
- CLEAR state:
  - Each cycle: if clrMask[part(clrIdx)] is set, write entry clrIdx with 0, then clrIdx++.
  - At clrIdx==DEPTH-1: clear that entry, go to READY, set ramReady_o<=1.
  - A full sweep therefore takes DEPTH cycles after reset deasserts; ramReady_o first reads 1 in cycle DEPTH+1.
  - User writes are dropped while in CLEAR.
- READY state:
  - For each write port w with wrEn_i[w]=1 whose target partition is active, write ram[addrWr_i[w]] <= dataWr_i[w].
  - Multiple ports writing the same address in one cycle: highest-numbered port wins.
  - Writes to a gated partition are dropped silently.
- Partition re-activation:
  - Track prevActive. Any bit going 0->1 while in READY: clrMask <= newly-set bits, clrIdx<=0, state<=CLEAR, ramReady_o<=0 next cycle.
  - The same edge in CLEAR: clrMask |= new bits and clrIdx restarts at 0.
  - Only masked partitions are zeroed; other entries are untouched.
  - User writes are still dropped everywhere during this sweep.
- Partition deactivation (1->0): no sequencing; contents become don't-care; reads of that partition return 0.
- Reads:
  - Combinational from addr_i.
  - data_o = 0 when the addressed partition is gated or state==CLEAR.
  - BYPASS=1 and READY: if any enabled write port (to an active partition) matches addr_i[r], data_o returns the winning port's dataWr_i in the same cycle.
  - BYPASS=0: the read returns the pre-write value; the new value is visible from the next cycle.
- Reset asserted mid-sweep or mid-write: reset dominates; the in-flight write is dropped and the sweep restarts from 0 with the full mask.
- prevActive <= partActive_i every cycle, including during reset (so reset does not itself cause a spurious re-activation sweep).

Test Plan:
- Reset held 3 cycles, then released with all partitions active -> ramReady_o=0 for 16 cycles, =1 on the 17th; all 16 entries read 0.
- READY, write port0 addr 5 data 0xA5 (BYPASS=1) -> data_o[port0] with addr_i=5 is 0xA5 in the same cycle and persists afterwards. Same case with BYPASS=0 -> old value in the write cycle, 0xA5 from the next cycle.
- Port0 writes 0x11 and port1 writes 0x22 to addr 9 in the same cycle -> entry 9 reads 0x22.
- Drop partActive_i[1] (entries 4-7) -> read addr 6 returns 0; a write of 0x33 to addr 6 is dropped. Re-raise the bit -> ramReady_o=0 for 16 cycles; entries 4-7 read 0; entry 9 still reads 0x22.
- During a partition-1 sweep at clrIdx=10, activate partition 3 -> sweep restarts at 0, both partitions cleared, ready after a further 16 cycles.
- Assert reset at clrIdx=7 together with wrEn_i=1 -> write dropped; full 16-cycle sweep restarts after reset is released.

Source files
------------

// File: rtl/stq_ram_mp_if.sv
// Store-queue data RAM bus: read addresses/data, write ports, partition
// power status and the array-ready flag.
interface stq_ram_mp_if #(
  parameter int RPORT     = 2,
  parameter int WPORT     = 2,
  parameter int INDEX     = 4,
  parameter int WIDTH     = 8,
  parameter int NUM_PARTS = 4
);
  logic [RPORT*INDEX-1:0] addr_i;
  logic [RPORT*WIDTH-1:0] data_o;
  logic [WPORT*INDEX-1:0] addrWr_i;
  logic [WPORT*WIDTH-1:0] dataWr_i;
  logic [WPORT-1:0]       wrEn_i;
  logic [NUM_PARTS-1:0]   partActive_i;
  logic                   ramReady_o;

  // Requester side: drives addresses, write data and partition status.
  modport master (
    output addr_i, addrWr_i, dataWr_i, wrEn_i, partActive_i,
    input  data_o, ramReady_o
  );

  // RAM side.
  modport slave (
    input  addr_i, addrWr_i, dataWr_i, wrEn_i, partActive_i,
    output data_o, ramReady_o
  );
endinterface

// File: rtl/stq_ram_mp.sv
// Multi-port store-queue data RAM with fixed-priority write ports,
// optional write-to-read bypass, partition gating and a clear sequencer
// that zeroes the array after reset and on partition re-activation.
module stq_ram_mp #(
  parameter int RPORT     = 2,
  parameter int WPORT     = 2,
  parameter int DEPTH     = 16,
  parameter int INDEX     = 4,
  parameter int WIDTH     = 8,
  parameter int NUM_PARTS = 4,
  parameter int BYPASS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  stq_ram_mp_if.slave   bus
);

  localparam int PBITS = $clog2(NUM_PARTS);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Partition of an entry: the top PBITS bits of its index.
  function automatic logic [PBITS-1:0] part_of(input logic [INDEX-1:0] addr);
    return addr[INDEX-1 -: PBITS];
  endfunction

  logic [0:0]           state_q,       state_d;
  logic [INDEX-1:0]     clr_idx_q,     clr_idx_d;
  logic [NUM_PARTS-1:0] clr_mask_q,    clr_mask_d;
  logic                 ready_q,       ready_d;
  logic [NUM_PARTS-1:0] prev_active_q, prev_active_d;
  logic [WIDTH-1:0]     ram_q [DEPTH];
  logic [WIDTH-1:0]     ram_d [DEPTH];

  logic [NUM_PARTS-1:0]   rise_s;
  logic [WPORT-1:0]       wr_ok_s;
  logic [RPORT*WIDTH-1:0] rd_data_s;
  logic [INDEX-1:0]       rd_addr_s;
  logic [WIDTH-1:0]       rd_val_s;

  assign rise_s = bus.partActive_i & ~prev_active_q;

  // A user write is live only in READY and only towards a powered partition.
  always_comb begin
    wr_ok_s = '0;
    for (int w = 0; w < WPORT; w++) begin
      wr_ok_s[w] = (state_q == ST_READY) && bus.wrEn_i[w] &&
                   bus.partActive_i[part_of(bus.addrWr_i[w*INDEX +: INDEX])];
    end
  end

  // Sequencer next state: sweep the masked partitions, restart on any new
  // partition power-up, and hand over to READY after the last entry.
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    clr_mask_d    = clr_mask_q;
    ready_d       = ready_q;
    prev_active_d = bus.partActive_i;
    case (state_q)
      ST_READY: begin
        if (|rise_s) begin
          state_d    = ST_CLEAR;
          clr_idx_d  = {INDEX{1'b0}};
          clr_mask_d = rise_s;
          ready_d    = 1'b0;
        end else begin
          ready_d    = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (|rise_s) begin
          clr_mask_d = clr_mask_q | rise_s;
          clr_idx_d  = {INDEX{1'b0}};
        end else if (clr_idx_q == INDEX'(DEPTH-1)) begin
          state_d    = ST_READY;
          ready_d    = 1'b1;
        end else begin
          clr_idx_d  = clr_idx_q + {{(INDEX-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_idx_d  = {INDEX{1'b0}};
        clr_mask_d = {NUM_PARTS{1'b1}};
        ready_d    = 1'b0;
      end
    endcase
  end

  // Array next contents: clear-sweep writes in CLEAR, user writes in READY
  // with the highest-numbered port applied last so it wins; reset drops all.
  always_comb begin
    ram_d = ram_q;
    if (reset) begin
      ram_d = ram_q;
    end else if (state_q == ST_CLEAR) begin
      if (clr_mask_q[part_of(clr_idx_q)]) begin
        ram_d[clr_idx_q] = {WIDTH{1'b0}};
      end else begin
        ram_d[clr_idx_q] = ram_q[clr_idx_q];
      end
    end else begin
      for (int w = 0; w < WPORT; w++) begin
        if (wr_ok_s[w]) begin
          ram_d[bus.addrWr_i[w*INDEX +: INDEX]] = bus.dataWr_i[w*WIDTH +: WIDTH];
        end else begin
          ram_d[bus.addrWr_i[w*INDEX +: INDEX]] = ram_d[bus.addrWr_i[w*INDEX +: INDEX]];
        end
      end
    end
  end

  // Asynchronous reads: optional same-cycle forwarding of the winning write,
  // forced to zero while clearing or when the partition is gated.
  always_comb begin
    rd_data_s = '0;
    rd_addr_s = '0;
    rd_val_s  = '0;
    for (int r = 0; r < RPORT; r++) begin
      rd_addr_s = bus.addr_i[r*INDEX +: INDEX];
      rd_val_s  = ram_q[rd_addr_s];
      for (int w = 0; w < WPORT; w++) begin
        if ((BYPASS != 0) && wr_ok_s[w] &&
            (bus.addrWr_i[w*INDEX +: INDEX] == rd_addr_s)) begin
          rd_val_s = bus.dataWr_i[w*WIDTH +: WIDTH];
        end else begin
          rd_val_s = rd_val_s;
        end
      end
      if ((state_q != ST_READY) || !bus.partActive_i[part_of(rd_addr_s)]) begin
        rd_val_s = {WIDTH{1'b0}};
      end else begin
        rd_val_s = rd_val_s;
      end
      rd_data_s[r*WIDTH +: WIDTH] = rd_val_s;
    end
  end

  // Sequencer registers; reset restarts a full sweep, partition history
  // follows the inputs even in reset so release causes no extra sweep.
  always_ff @(posedge clk) begin
    prev_active_q <= prev_active_d;
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= {INDEX{1'b0}};
      clr_mask_q <= {NUM_PARTS{1'b1}};
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      clr_mask_q <= clr_mask_d;
      ready_q    <= ready_d;
    end
  end

  // Storage array; contents are only ever initialised by the clear sweep.
  always_ff @(posedge clk) begin
    ram_q <= ram_d;
  end

  assign bus.data_o     = rd_data_s;
  assign bus.ramReady_o = ready_q;

endmodule

// File: tb/tb_stq_ram_mp.sv
// Directed bench for stq_ram_mp: a BYPASS=1 instance driven by the bench and
// a BYPASS=0 instance mirroring the same inputs.
module tb_stq_ram_mp;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stq_ram_mp_if #(.RPORT(2), .WPORT(2), .INDEX(4), .WIDTH(8), .NUM_PARTS(4)) bus0 ();
  stq_ram_mp_if #(.RPORT(2), .WPORT(2), .INDEX(4), .WIDTH(8), .NUM_PARTS(4)) bus1 ();

  assign bus1.addr_i       = bus0.addr_i;
  assign bus1.addrWr_i     = bus0.addrWr_i;
  assign bus1.dataWr_i     = bus0.dataWr_i;
  assign bus1.wrEn_i       = bus0.wrEn_i;
  assign bus1.partActive_i = bus0.partActive_i;

  stq_ram_mp #(.RPORT(2), .WPORT(2), .DEPTH(16), .INDEX(4), .WIDTH(8),
               .NUM_PARTS(4), .BYPASS(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  stq_ram_mp #(.RPORT(2), .WPORT(2), .DEPTH(16), .INDEX(4), .WIDTH(8),
               .NUM_PARTS(4), .BYPASS(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [3:0] addr);
    bus0.addr_i[port*4 +: 4] = addr;
  endtask

  task automatic set_wr(input int port, input logic [3:0] addr, input logic [7:0] data, input logic en);
    bus0.addrWr_i[port*4 +: 4] = addr;
    bus0.dataWr_i[port*8 +: 8] = data;
    bus0.wrEn_i[port]          = en;
  endtask

  // Read one address on port 0 of the bypassing instance after settling.
  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    set_rd(0, addr);
    #1;
    check_val(tag, {24'h0, bus0.data_o[7:0]}, {24'h0, exp});
  endtask

  initial begin
    reset             = 1'b1;
    bus0.addr_i       = '0;
    bus0.addrWr_i     = '0;
    bus0.dataWr_i     = '0;
    bus0.wrEn_i       = '0;
    bus0.partActive_i = 4'hF;
    repeat (3) step();
    check_val("reset_ready", {31'h0, bus0.ramReady_o}, 32'h0);
    check_val("reset_data", {24'h0, bus0.data_o[7:0]}, 32'h0);

    // Power-on sweep: ready only after the sixteenth edge.
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check_val($sformatf("init_ready_%0d", k), {31'h0, bus0.ramReady_o}, (k == 16) ? 32'h1 : 32'h0);
    end
    check_val("init_ready_nobyp", {31'h0, bus1.ramReady_o}, 32'h1);
    for (int a = 0; a < 16; a++) begin
      set_rd(1, 4'(15 - a));
      read_chk($sformatf("init_zero_%0d", a), 4'(a), 8'h00);
      check_val($sformatf("init_zero_p1_%0d", a), {24'h0, bus0.data_o[15:8]}, 32'h0);
    end

    // Single write with bypass vs. no bypass.
    set_wr(0, 4'd5, 8'hA5, 1'b1);
    read_chk("byp_same_cycle", 4'd5, 8'hA5);
    check_val("nobyp_same_cycle", {24'h0, bus1.data_o[7:0]}, 32'h0);
    step();
    set_wr(0, 4'd0, 8'h00, 1'b0);
    read_chk("byp_after", 4'd5, 8'hA5);
    check_val("nobyp_after", {24'h0, bus1.data_o[7:0]}, 32'hA5);

    // Two ports to one address: port 1 wins, also on the bypass path.
    set_wr(0, 4'd9, 8'h11, 1'b1);
    set_wr(1, 4'd9, 8'h22, 1'b1);
    set_rd(1, 4'd9);
    read_chk("prio_bypass", 4'd9, 8'h22);
    check_val("prio_bypass_p1", {24'h0, bus0.data_o[15:8]}, 32'h22);
    step();
    set_wr(0, 4'd0, 8'h00, 1'b0);
    set_wr(1, 4'd0, 8'h00, 1'b0);
    read_chk("prio_stored", 4'd9, 8'h22);
    check_val("prio_stored_nobyp", {24'h0, bus1.data_o[7:0]}, 32'h22);

    // Entry 0 and 12 get known values to prove later sweeps spare them / clear them.
    set_wr(0, 4'd0, 8'h99, 1'b1);
    set_wr(1, 4'd12, 8'h77, 1'b1);
    step();
    set_wr(0, 4'd0, 8'h00, 1'b0);
    set_wr(1, 4'd0, 8'h00, 1'b0);
    read_chk("entry0_written", 4'd0, 8'h99);
    read_chk("entry12_written", 4'd12, 8'h77);

    // Gate partition 1: reads return 0, writes are dropped.
    bus0.partActive_i = 4'b1101;
    read_chk("gated_read6", 4'd6, 8'h00);
    read_chk("gated_read5", 4'd5, 8'h00);
    read_chk("ungated_read9", 4'd9, 8'h22);
    set_wr(0, 4'd6, 8'h33, 1'b1);
    read_chk("gated_no_bypass", 4'd6, 8'h00);
    step();
    set_wr(0, 4'd0, 8'h00, 1'b0);
    check_val("gated_ready", {31'h0, bus0.ramReady_o}, 32'h1);

    // Re-raise partition 1: sweep of partition 1 only.
    bus0.partActive_i = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      step();
      check_val($sformatf("react_ready_%0d", k), {31'h0, bus0.ramReady_o}, (k == 17) ? 32'h1 : 32'h0);
    end
    read_chk("react_e5", 4'd5, 8'h00);
    read_chk("react_e6", 4'd6, 8'h00);
    read_chk("react_e9", 4'd9, 8'h22);
    read_chk("react_e0", 4'd0, 8'h99);

    // Partition 1 sweep restarted at clrIdx=10 by partition 3 power-up.
    bus0.partActive_i = 4'b0101;
    step();
    set_wr(0, 4'd4, 8'h66, 1'b0);
    bus0.partActive_i = 4'b0111;
    repeat (11) step();
    check_val("mid_ready_low", {31'h0, bus0.ramReady_o}, 32'h0);
    read_chk("mid_clear_reads0", 4'd9, 8'h00);
    bus0.partActive_i = 4'b1111;
    set_wr(0, 4'd0, 8'h55, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      step();
      check_val($sformatf("mid_ready_%0d", k), {31'h0, bus0.ramReady_o}, (k == 17) ? 32'h1 : 32'h0);
    end
    set_wr(0, 4'd0, 8'h00, 1'b0);
    read_chk("mid_e12", 4'd12, 8'h00);
    read_chk("mid_e5", 4'd5, 8'h00);
    read_chk("mid_e9", 4'd9, 8'h22);
    read_chk("mid_e0_dropped", 4'd0, 8'h99);

    // Reset at clrIdx=7 of a partition-0 sweep, with a write pending.
    bus0.partActive_i = 4'b1110;
    step();
    bus0.partActive_i = 4'b1111;
    repeat (8) step();
    reset = 1'b1;
    set_wr(1, 4'd9, 8'h5A, 1'b1);
    step();
    check_val("rst_mid_ready", {31'h0, bus0.ramReady_o}, 32'h0);
    reset = 1'b0;
    set_wr(1, 4'd0, 8'h00, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check_val($sformatf("rst_mid_ready_%0d", k), {31'h0, bus0.ramReady_o}, (k == 16) ? 32'h1 : 32'h0);
    end
    read_chk("rst_mid_e9", 4'd9, 8'h00);
    read_chk("rst_mid_e0", 4'd0, 8'h00);
    read_chk("rst_mid_e12", 4'd12, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
